// File: rtl/quad_enc_pkg.sv
// Shared types and helpers for the quadrature encoder front end:
// tracker state encoding, Gray-code step constants and step classification.
package quad_enc_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } enc_state_t;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  typedef struct packed {
    logic valid;    // exactly one phase changed
    logic dir;      // 1 = up, 0 = down (meaningful only when valid)
    logic illegal;  // both phases changed at once
  } step_t;

  // Up order is 00 -> 01 -> 11 -> 10 -> 00; any other single-bit change is a down step.
  function automatic step_t step_dir(input logic [1:0] prev, input logic [1:0] cur);
    step_t      s;
    logic [1:0] up_next;
    s = '0;
    case (prev)
      AB_00:   up_next = AB_01;
      AB_01:   up_next = AB_11;
      AB_11:   up_next = AB_10;
      default: up_next = AB_00;
    endcase
    if ((cur ^ prev) == 2'b11) begin
      s.illegal = 1'b1;
    end else if (cur != prev) begin
      s.valid = 1'b1;
      s.dir   = (cur == up_next);
    end
    return s;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// One-bit 2-FF synchronizer followed by a run-length filter: the output takes a
// new level only after DEB_CYCLES consecutive synchronized samples disagree with it.
module debounce_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the sync chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      run_cnt <= '0;
      dout    <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(DEB_CYCLES - 1)) begin
        dout    <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_front_end.sv
// Quadrature encoder front end: debounced A/B/index, Gray-code step decode into
// count-enable pulses with direction, and index-triggered preset load.
module quad_encoder_front_end
  import quad_enc_pkg::*;
#(
  parameter int Nbits      = 4,
  parameter int DEB_CYCLES = 4,
  parameter int DECODE_X4  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_i,
  input  logic             idx_en,
  input  logic [Nbits-1:0] preset,
  output logic             ena,
  output logic             UpDwn,
  output logic             Load,
  output logic [Nbits-1:0] Data,
  output logic             err
);

  // INIT waits until the filters have had time to settle on the real pin levels.
  localparam int INIT_LEN = DEB_CYCLES + 3;
  localparam int IW       = $clog2(INIT_LEN);

  logic             filt_a, filt_b, filt_i;
  logic [1:0]       cur_ab;
  logic             idx_d;
  enc_state_t       state, state_n;
  logic [IW-1:0]    init_cnt, init_cnt_n;
  logic [1:0]       prev_ab, prev_ab_n;
  logic             ena_n, updwn_n, load_n, err_n;
  logic [Nbits-1:0] data_n;
  logic             load_fire;
  step_t            step;

  debounce_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt_a (.clk(clk), .rst(rst), .din(enc_a), .dout(filt_a));
  debounce_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt_b (.clk(clk), .rst(rst), .din(enc_b), .dout(filt_b));
  debounce_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt_i (.clk(clk), .rst(rst), .din(enc_i), .dout(filt_i));

  assign cur_ab = {filt_a, filt_b};

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    prev_ab_n  = prev_ab;
    ena_n      = 1'b0;
    err_n      = 1'b0;
    load_n     = 1'b0;
    updwn_n    = UpDwn;
    data_n     = Data;
    load_fire  = 1'b0;
    step       = step_dir(prev_ab, cur_ab);
    case (state)
      INIT: begin
        if (init_cnt == IW'(INIT_LEN - 1)) begin
          state_n   = TRACK;
          prev_ab_n = cur_ab;
        end else begin
          init_cnt_n = init_cnt + 1'b1;
        end
      end
      TRACK: begin
        load_fire = idx_en & filt_i & ~idx_d;
        if (step.valid) begin
          prev_ab_n = cur_ab;
          updwn_n   = step.dir;
          // Index load takes priority over the count pulse; direction still tracks.
          ena_n     = ((DECODE_X4 != 0) || (cur_ab == AB_00)) && !load_fire;
        end
        if (step.illegal) begin
          prev_ab_n = cur_ab;
          err_n     = 1'b1;
        end
        if (load_fire) begin
          load_n = 1'b1;
          data_n = preset;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
      prev_ab  <= AB_00;
      idx_d    <= 1'b0;
      ena      <= 1'b0;
      UpDwn    <= 1'b0;
      Load     <= 1'b0;
      Data     <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
      prev_ab  <= prev_ab_n;
      idx_d    <= filt_i;
      ena      <= ena_n;
      UpDwn    <= updwn_n;
      Load     <= load_n;
      Data     <= data_n;
      err      <= err_n;
    end
  end

endmodule
